// File: rtl/hidden_layer_mac.sv
// Hidden-layer neuron engine: one double-precision multiply-accumulate per cycle,
// bias add and ReLU per neuron, results held in a readable mid_out array.
module hidden_layer_mac #(
   parameter  int unsigned N_IN  = 4,
   parameter  int unsigned N_HID = 10,
   localparam int unsigned AW_X  = $clog2(N_IN + 1),
   localparam int unsigned AW_H  = $clog2(N_HID)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            x_we,
   input  logic [AW_X-1:0] x_addr,
   input  logic [63:0]     x_data,
   input  logic            w_we,
   input  logic [AW_H-1:0] w_neuron,
   input  logic [AW_X-1:0] w_idx,
   input  logic [63:0]     w_data,
   input  logic            start,
   output logic            busy,
   output logic            done_act_1,
   input  logic [AW_H-1:0] mid_rd_addr,
   output logic [63:0]     mid_rd_data
);

   localparam int unsigned AW_K = (N_IN > 1) ? $clog2(N_IN) : 1;
   localparam logic [AW_X-1:0] K_LAST = AW_X'(N_IN - 1);
   localparam logic [AW_X-1:0] K_BIAS = AW_X'(N_IN);
   localparam logic [AW_H-1:0] N_LAST = AW_H'(N_HID - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MAC  = 2'd1,
      S_FIN  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic            w_busy_nxt;
   logic            w_done_nxt;
   logic            r_busy;
   logic            r_done;
   logic [AW_H-1:0] r_n;
   logic [AW_X-1:0] r_k;
   logic [63:0]     r_acc;
   logic [63:0]     r_mid_rd_data;
   logic [63:0]     r_mid [N_HID];
   logic [63:0]     r_x   [N_IN];
   logic [63:0]     r_w   [N_HID][N_IN+1];
   logic [63:0]     w_mac;
   logic [63:0]     w_sum;
   logic [63:0]     w_relu;
   logic            w_idle;

   // Double-precision operators; the product is rounded before the add (no fused MAC).
   function automatic logic [63:0] f_mac(input logic [63:0] a, input logic [63:0] b,
                                         input logic [63:0] c);
      return $realtobits($bitstoreal(a) + $bitstoreal(b) * $bitstoreal(c));
   endfunction

   function automatic logic [63:0] f_add(input logic [63:0] a, input logic [63:0] b);
      return $realtobits($bitstoreal(a) + $bitstoreal(b));
   endfunction

   // NaN and strictly positive values pass; every zero or negative value becomes +0.0.
   function automatic logic [63:0] f_relu(input logic [63:0] s);
      logic is_nan;
      logic is_pos;
      is_nan = (s[62:52] == 11'h7FF) && (s[51:0] != 52'h0);
      is_pos = !s[63] && (s[62:0] != 63'h0);
      return (is_nan || is_pos) ? s : 64'h0;
   endfunction

   assign w_idle = (r_state == S_IDLE);
   assign w_mac  = f_mac(r_acc, r_w[r_n][r_k], r_x[r_k[AW_K-1:0]]);
   assign w_sum  = f_add(r_acc, r_w[r_n][K_BIAS]);
   assign w_relu = f_relu(w_sum);

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE:  if (start) w_state_nxt = S_MAC;
         S_MAC:   if (r_k == K_LAST) w_state_nxt = S_FIN;
         S_FIN:   w_state_nxt = (r_n == N_LAST) ? S_DONE : S_MAC;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_busy_nxt = 1'b0;
      w_done_nxt = 1'b0;
      w_busy_nxt = (w_state_nxt != S_IDLE);
      w_done_nxt = (r_state == S_DONE);
   end

   // Control counters, accumulator, result array and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_n           <= '0;
         r_k           <= '0;
         r_acc         <= '0;
         r_mid_rd_data <= '0;
         for (int i = 0; i < int'(N_HID); i++) r_mid[i] <= '0;
      end else begin
         r_busy        <= w_busy_nxt;
         r_done        <= w_done_nxt;
         r_mid_rd_data <= (32'(mid_rd_addr) < N_HID) ? r_mid[mid_rd_addr] : 64'h0;
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_n   <= '0;
                  r_k   <= '0;
                  r_acc <= '0;
               end
            end
            S_MAC: begin
               r_acc <= w_mac;
               r_k   <= r_k + AW_X'(1);
            end
            S_FIN: begin
               r_mid[r_n] <= w_relu;
               r_acc      <= '0;
               r_k        <= '0;
               if (r_n != N_LAST) r_n <= r_n + AW_H'(1);
            end
            default: ;
         endcase
      end
   end

   // Feature and weight memories: writable only while idle, not reset.
   always_ff @(posedge clk) begin
      if (w_idle && x_we && (32'(x_addr) < N_IN))
         r_x[x_addr[AW_K-1:0]] <= x_data;
      if (w_idle && w_we && (32'(w_neuron) < N_HID) && (32'(w_idx) <= N_IN))
         r_w[w_neuron][w_idx] <= w_data;
   end

   assign busy        = r_busy;
   assign done_act_1  = r_done;
   assign mid_rd_data = r_mid_rd_data;

endmodule

// File: tb/tb_hidden_layer_mac.sv
// Directed bench for hidden_layer_mac: nominal run, ReLU clamp, busy protection,
// mid-run reset, back-to-back runs and the read port.
module tb_hidden_layer_mac;

   localparam int unsigned N_IN  = 4;
   localparam int unsigned N_HID = 10;
   localparam int unsigned AW_X  = $clog2(N_IN + 1);
   localparam int unsigned AW_H  = $clog2(N_HID);

   logic            clk = 1'b0;
   logic            rst_n;
   logic            x_we;
   logic [AW_X-1:0] x_addr;
   logic [63:0]     x_data;
   logic            w_we;
   logic [AW_H-1:0] w_neuron;
   logic [AW_X-1:0] w_idx;
   logic [63:0]     w_data;
   logic            start;
   logic            busy;
   logic            done_act_1;
   logic [AW_H-1:0] mid_rd_addr;
   logic [63:0]     mid_rd_data;

   int total = 0;
   int bad   = 0;

   real mx [N_IN];
   real mw [N_HID][N_IN+1];

   hidden_layer_mac dut (
      .clk(clk), .rst_n(rst_n),
      .x_we(x_we), .x_addr(x_addr), .x_data(x_data),
      .w_we(w_we), .w_neuron(w_neuron), .w_idx(w_idx), .w_data(w_data),
      .start(start), .busy(busy), .done_act_1(done_act_1),
      .mid_rd_addr(mid_rd_addr), .mid_rd_data(mid_rd_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference neuron: products in ascending k, then bias, then ReLU.
   function automatic logic [63:0] model(input int n);
      real acc;
      real s;
      acc = 0.0;
      for (int k = 0; k < int'(N_IN); k++) acc = acc + mw[n][k] * mx[k];
      s = acc + mw[n][N_IN];
      return (s > 0.0) ? $realtobits(s) : 64'h0;
   endfunction

   task automatic wr_x(input int a, input real v);
      x_we = 1'b1; x_addr = AW_X'(a); x_data = $realtobits(v);
      mx[a] = v;
      tick();
      x_we = 1'b0;
   endtask

   task automatic wr_w(input int n, input int i, input real v);
      w_we = 1'b1; w_neuron = AW_H'(n); w_idx = AW_X'(i); w_data = $realtobits(v);
      mw[n][i] = v;
      tick();
      w_we = 1'b0;
   endtask

   task automatic rd(input int a, output logic [63:0] v);
      mid_rd_addr = AW_H'(a);
      tick();
      v = mid_rd_data;
   endtask

   task automatic check_all(input string tag);
      logic [63:0] v;
      for (int n = 0; n < int'(N_HID); n++) begin
         rd(n, v);
         check($sformatf("%s_mid%0d", tag, n), v, model(n));
      end
   endtask

   // One run; optional mid-run blocked write + start (wr_at) or reset pulse (rst_at).
   task automatic run(input int wr_at, input int rst_at, output int lat);
      lat = -1;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("busy_on", 64'(busy), 64'd1);
      for (int c = 1; c <= 120; c++) begin
         if (c == wr_at) begin
            start = 1'b1; w_we = 1'b1; w_neuron = AW_H'(1); w_idx = '0;
            w_data = $realtobits(100.0);
         end
         if (c == rst_at) rst_n = 1'b0;
         tick();
         start = 1'b0; w_we = 1'b0;
         if (c == rst_at) begin
            rst_n = 1'b1;
            check("busy_after_rst", 64'(busy), 64'd0);
         end
         if (done_act_1) begin
            lat = c;
            break;
         end
      end
      if (lat > 0) begin
         check("busy_at_done", 64'(busy), 64'd0);
         tick();
         check("done_one_cycle", 64'(done_act_1), 64'd0);
      end
   endtask

   initial begin
      logic [63:0] v;
      int lat;
      int first;
      int second;
      rst_n = 1'b0; x_we = 1'b0; x_addr = '0; x_data = '0;
      w_we = 1'b0; w_neuron = '0; w_idx = '0; w_data = '0;
      start = 1'b0; mid_rd_addr = '0;
      tick(); tick();
      rst_n = 1'b1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done_act_1), 64'd0);
      check("rst_rd", mid_rd_data, 64'h0);
      rd(9, v);
      check("rst_mid9", v, 64'h0);

      // Nominal load; x and w[0] written in the same cycles.
      for (int k = 0; k < int'(N_IN); k++) begin
         x_we = 1'b1; x_addr = AW_X'(k); x_data = $realtobits(real'(k + 1));
         mx[k] = real'(k + 1);
         w_we = 1'b1; w_neuron = '0; w_idx = AW_X'(k); w_data = $realtobits(0.5);
         mw[0][k] = 0.5;
         tick();
      end
      x_we = 1'b0; w_we = 1'b0;
      wr_w(0, N_IN, -1.0);
      for (int n = 1; n < int'(N_HID); n++)
         for (int i = 0; i <= int'(N_IN); i++) wr_w(n, i, (i == int'(N_IN)) ? 0.0 : 0.5);

      run(0, 0, lat);
      check("nom_latency", 64'(lat), 64'd51);
      rd(0, v); check("nom_mid0", v, $realtobits(4.0));
      rd(1, v); check("nom_mid1", v, $realtobits(5.0));
      check_all("nom");

      // ReLU clamp: negative sum, +0 + -0 sum, NaN bias.
      wr_w(3, N_IN, -10.0);
      for (int k = 0; k < int'(N_IN); k++) wr_w(4, k, 0.0);
      wr_w(4, N_IN, -0.0);
      w_we = 1'b1; w_neuron = AW_H'(5); w_idx = AW_X'(N_IN); w_data = 64'h7FF8_0000_0000_0001;
      tick();
      w_we = 1'b0;
      run(0, 0, lat);
      check("relu_latency", 64'(lat), 64'd51);
      rd(3, v); check("relu_neg", v, 64'h0);
      rd(4, v); check("relu_zero", v, 64'h0);
      rd(5, v); check("relu_nan", 64'((v[62:52] == 11'h7FF) && (v[51:0] != 52'h0)), 64'd1);
      rd(6, v); check("relu_mid6", v, $realtobits(5.0));
      wr_w(3, N_IN, 0.0);
      for (int k = 0; k < int'(N_IN); k++) wr_w(4, k, 0.5);
      wr_w(4, N_IN, 0.0);
      wr_w(5, N_IN, 0.0);

      // Start and weight write while busy are both ignored.
      run(10, 0, lat);
      check("busy_latency", 64'(lat), 64'd51);
      check("busy_no_restart", 64'(busy), 64'd0);
      run(0, 0, lat);
      rd(1, v); check("busy_w_kept", v, $realtobits(5.0));

      // Reset mid-run: aborted, results cleared, memories retained.
      run(0, 20, lat);
      check("rst_no_done", 64'(lat), 64'hFFFF_FFFF_FFFF_FFFF);
      for (int n = 0; n < int'(N_HID); n++) begin
         rd(n, v);
         check($sformatf("rst_clr%0d", n), v, 64'h0);
      end
      run(0, 0, lat);
      check("rerun_latency", 64'(lat), 64'd51);
      check_all("rerun");

      // Back-to-back: start held high, x[3] changed during the done cycle.
      first = -1; second = -1;
      start = 1'b1;
      for (int c = 1; c <= 200; c++) begin
         tick();
         if (done_act_1) begin
            if (first < 0) begin
               first = c;
               x_we = 1'b1; x_addr = AW_X'(3); x_data = $realtobits(8.0);
               mx[3] = 8.0;
            end else begin
               second = c;
               start = 1'b0;
               break;
            end
         end else begin
            x_we = 1'b0;
         end
      end
      start = 1'b0; x_we = 1'b0;
      check("b2b_seen", 64'((first > 0) && (second > 0)), 64'd1);
      check("b2b_period", 64'(second - first), 64'd52);
      tick();
      check("b2b_idle", 64'(busy), 64'd0);
      rd(0, v); check("b2b_mid0", v, $realtobits(6.0));
      rd(1, v); check("b2b_mid1", v, $realtobits(7.0));
      check_all("b2b");

      // Read port latency and out-of-range address.
      rd(0, v);
      mid_rd_addr = AW_H'(9);
      tick();
      check("rd_addr9", mid_rd_data, $realtobits(7.0));
      mid_rd_addr = AW_H'(15);
      tick();
      check("rd_addr15", mid_rd_data, 64'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
